// File: rtl/data_sram_resp.sv
// Data-side SRAM model for the core LSU: 64-bit words, byte-masked writes,
// fixed response latency of 1+WAIT_CYCLES cycles with stall handshake.
module data_sram_resp #(
  parameter int          ADDR_WD     = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_sram_en,
  input  logic [7:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        stall_req,
  output logic        resp_valid,
  output logic        addr_err
);

  // state | meaning
  // IDLE  | no request outstanding, may accept
  // WAIT  | request accepted, counting down extra latency; inputs ignored
  // RESP  | response cycle (resp_valid=1), may accept the next request
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int          DEPTH     = 1 << ADDR_WD;
  localparam logic [32:0] SPAN      = 33'(DEPTH) * 33'd8;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t             state;
  logic [3:0]         cnt;
  logic               rd_q;
  logic               in_q;
  logic [ADDR_WD-1:0] idx_q;

  logic [63:0]        mem [DEPTH];

  logic [31:0]        offset;
  logic               in_range;
  logic [ADDR_WD-1:0] idx;
  logic               accept;
  logic               is_read;
  logic               rd_fire;
  logic               rd_in;
  logic [ADDR_WD-1:0] rd_idx;

  assign offset   = data_sram_addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);
  assign idx      = offset[ADDR_WD+2:3];
  assign is_read  = (data_sram_we == 8'h00);
  assign accept   = rst_n && data_sram_en && ((state == IDLE) || (state == RESP));

  // The last WAIT cycle is not stalled, so each request costs exactly WAIT_CYCLES stalls.
  assign stall_req = (WAIT_CYCLES > 0) && rst_n &&
                     (accept || ((state == WAIT) && (cnt != 4'd0)));

  // Array sample point: the accept edge when there is no wait, else the last WAIT edge.
  always_comb begin
    rd_fire = 1'b0;
    rd_in   = 1'b0;
    rd_idx  = '0;
    if (WAIT_CYCLES == 0) begin
      rd_fire = accept && is_read;
      rd_in   = in_range;
      rd_idx  = idx;
    end else begin
      rd_fire = (state == WAIT) && (cnt == 4'd0) && rd_q;
      rd_in   = in_q;
      rd_idx  = idx_q;
    end
  end

  // Array is deliberately not reset; an accepted write commits at its accept edge.
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (data_sram_we[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      rd_q            <= 1'b0;
      in_q            <= 1'b0;
      idx_q           <= '0;
      data_sram_rdata <= 64'h0;
      resp_valid      <= 1'b0;
      addr_err        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      addr_err   <= 1'b0;
      if (rd_fire) data_sram_rdata <= rd_in ? mem[rd_idx] : 64'h0;
      case (state)
        IDLE, RESP: begin
          if (data_sram_en) begin
            rd_q  <= is_read;
            in_q  <= in_range;
            idx_q <= idx;
            if (WAIT_CYCLES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              addr_err   <= !in_range;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            addr_err   <= !in_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomized scoreboard bench for data_sram_resp: one instance with no wait
// states and one with WAIT_CYCLES=3, both checked against a word-array model.
module tb_data_sram_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    bit          is_rd;
    logic [63:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0 = 1'b0, rst3 = 1'b0;
  logic        en0 = 1'b0, en3 = 1'b0;
  logic [7:0]  we0 = '0, we3 = '0;
  logic [31:0] addr0 = '0, addr3 = '0;
  logic [63:0] wdata0 = '0, wdata3 = '0;
  logic [63:0] rdata0, rdata3;
  logic        stall0, stall3, rv0, rv3, err0, err3;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic rst_seen0 = 1'b0, rst_seen3 = 1'b0;
  logic [63:0] vis0 = '0, vis3 = '0;
  exp_t q0[$], q3[$];
  logic [63:0] mem_m [int];
  int idx_list[7] = '{0, 1, 2, 3, 5, 1022, 1023};

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_WD(10), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0), .data_sram_en(en0), .data_sram_we(we0),
    .data_sram_addr(addr0), .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
    .stall_req(stall0), .resp_valid(rv0), .addr_err(err0));

  data_sram_resp #(.ADDR_WD(10), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3), .data_sram_en(en3), .data_sram_we(we3),
    .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
    .stall_req(stall3), .resp_valid(rv3), .addr_err(err3));

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rst_seen0 <= rst0;
    rst_seen3 <= rst3;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input int s, input logic [63:0] rd, input logic err);
    exp_t e;
    bit empty;
    empty = (s == 0) ? (q0.size() == 0) : (q3.size() == 0);
    if (empty) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_resp dut%0d: resp_valid=1 with nothing outstanding (cycle %0d)", s, cyc);
    end else begin
      e = (s == 0) ? q0.pop_front() : q3.pop_front();
      chk($sformatf("resp_cycle%0d", s), 64'(cyc), 64'(e.cyc));
      chk($sformatf("addr_err%0d", s), {63'd0, err}, {63'd0, e.err});
      if (e.is_rd) begin
        chk($sformatf("rdata_read%0d", s), rd, e.data);
        if (s == 0) vis0 = e.data; else vis3 = e.data;
      end else begin
        chk($sformatf("rdata_write_hold%0d", s), rd, (s == 0) ? vis0 : vis3);
      end
    end
  endtask

  // Monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_seen0 !== 1'b1) begin
      chk("reset_rdata0", rdata0, 64'h0);
      chk("reset_valid0", {63'd0, rv0}, 64'h0);
      chk("reset_err0", {63'd0, err0}, 64'h0);
      vis0 = 64'h0;
    end else begin
      chk("stall0_never", {63'd0, stall0}, 64'h0);
      if (rv0) pop_check(0, rdata0, err0);
      else chk("rdata_hold0", rdata0, vis0);
    end
    if (rst_seen3 !== 1'b1) begin
      chk("reset_rdata3", rdata3, 64'h0);
      chk("reset_valid3", {63'd0, rv3}, 64'h0);
      chk("reset_err3", {63'd0, err3}, 64'h0);
      vis3 = 64'h0;
    end else begin
      if (rv3) pop_check(1, rdata3, err3);
      else chk("rdata_hold3", rdata3, vis3);
    end
  end

  task automatic drive(input int s, input logic en, input logic [7:0] we,
                       input logic [31:0] a, input logic [63:0] wd);
    if (s == 0) begin en0 = en; we0 = we; addr0 = a; wdata0 = wd; end
    else        begin en3 = en; we3 = we; addr3 = a; wdata3 = wd; end
  endtask

  // Word-array model: in range iff (addr-BASE) mod 2^32 < 8 KiB; word = offset/8.
  task automatic model(input int s, input logic [7:0] we, input logic [31:0] a,
                       input logic [63:0] wd, output exp_t e);
    logic [31:0] off;
    bit inr;
    int key;
    logic [63:0] cur;
    off = a - BASE;
    inr = (off < 32'd8192);
    key = s * 2048 + (int'(off >> 3) & 1023);
    e.is_rd = (we == 8'h00);
    e.err   = !inr;
    e.data  = 64'h0;
    e.cyc   = 0;
    if (inr) begin
      if (e.is_rd) begin
        e.data = mem_m.exists(key) ? mem_m[key] : 64'h0;
      end else begin
        cur = mem_m.exists(key) ? mem_m[key] : 64'h0;
        for (int i = 0; i < 8; i++) if (we[i]) cur[8*i +: 8] = wd[8*i +: 8];
        mem_m[key] = cur;
      end
    end
  endtask

  // Called just after a falling edge while the DUT can accept; returns on the
  // falling edge of the response cycle. Inputs are scrambled while stalled.
  task automatic issue(input int s, input logic [7:0] we, input logic [31:0] a,
                       input logic [63:0] wd);
    exp_t e;
    int w, hi;
    bit st, done;
    w = (s == 0) ? 0 : 3;
    model(s, we, a, wd, e);
    e.cyc = cyc + 1 + w;
    if (s == 0) q0.push_back(e); else q3.push_back(e);
    drive(s, 1'b1, we, a, wd);
    hi = 0;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      st = (s == 0) ? stall0 : stall3;
      @(negedge clk);
      if (st) begin
        hi++;
        drive(s, 1'($urandom_range(0, 1)), 8'($urandom), $urandom, {$urandom, $urandom});
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stall_timeout dut%0d: stall_req still high after 20 cycles", s);
    end
    chk($sformatf("stall_cycles%0d", s), 64'(hi), 64'(w));
    drive(s, 1'b0, 8'h00, 32'h0, 64'h0);
  endtask

  task automatic idle(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      drive(s, 1'b0, 8'($urandom), $urandom, {$urandom, $urandom});
      @(negedge clk);
    end
    drive(s, 1'b0, 8'h00, 32'h0, 64'h0);
  endtask

  // Reset asserted for one cycle right after acceptance on the WAIT_CYCLES=3 instance.
  task automatic rst_mid(input logic [7:0] we, input logic [31:0] a, input logic [63:0] wd);
    exp_t e;
    model(1, we, a, wd, e);
    drive(1, 1'b1, we, a, wd);
    @(negedge clk);
    drive(1, 1'b0, 8'h00, 32'h0, 64'h0);
    rst3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    chk("rst_mid_rdata", rdata3, 64'h0);
    chk("rst_mid_valid", {63'd0, rv3}, 64'h0);
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return BASE + 32'(idx_list[r] * 8) + 32'($urandom_range(0, 7));
    else if (r == 7) return BASE + 32'd8192 + 32'(8 * $urandom_range(0, 15));
    else if (r == 8) return BASE - 32'(8 * $urandom_range(1, 4));
    else             return $urandom & 32'h7FFF_FFF8;
  endfunction

  task automatic random_phase(input int s, input int n);
    logic [7:0] we;
    int gap;
    for (int k = 0; k < 7; k++)
      issue(s, 8'hFF, BASE + 32'(idx_list[k] * 8), {$urandom, $urandom});
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        issue(s, 8'h00, pick_addr(), {$urandom, $urandom});
      end else begin
        we = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 3) == 0) we = 8'hFF;
        issue(s, we, pick_addr(), {$urandom, $urandom});
      end
      gap = $urandom_range(0, 3);
      if (gap >= 2) idle(s, gap - 1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst0 = 1'b1;
    rst3 = 1'b1;

    // No-wait instance: directed cases first.
    issue(0, 8'hFF, 32'h8000_0008, 64'h1122_3344_5566_7788);
    issue(0, 8'h00, 32'h8000_0008, 64'h0);
    chk("dir_rd_after_wr_valid", {63'd0, rv0}, 64'h1);
    chk("dir_rd_after_wr_data", rdata0, 64'h1122_3344_5566_7788);
    issue(0, 8'h0F, 32'h8000_0008, 64'hAAAA_AAAA_AAAA_AAAA);
    issue(0, 8'h00, 32'h8000_0008, 64'h0);
    chk("dir_bytemask_data", rdata0, 64'h1122_3344_AAAA_AAAA);
    issue(0, 8'h00, 32'h8000_2000, 64'h0);
    chk("dir_oor_rdata", rdata0, 64'h0);
    chk("dir_oor_err", {63'd0, err0}, 64'h1);
    issue(0, 8'hFF, 32'h8000_1FF8, 64'h0123_4567_89AB_CDEF);
    issue(0, 8'hFF, 32'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF);
    issue(0, 8'h00, 32'h8000_1FF8, 64'h0);
    chk("dir_oor_write_discarded", rdata0, 64'h0123_4567_89AB_CDEF);
    random_phase(0, 70);
    idle(0, 4);

    // WAIT_CYCLES=3 instance.
    issue(1, 8'hFF, 32'h8000_0010, 64'hCAFE_F00D_1234_5678);
    issue(1, 8'h00, 32'h8000_0010, 64'h0);
    chk("w3_rd_valid", {63'd0, rv3}, 64'h1);
    chk("w3_rd_data", rdata3, 64'hCAFE_F00D_1234_5678);
    rst_mid(8'h00, 32'h8000_0010, 64'h0);
    idle(1, 8);
    issue(1, 8'h00, 32'h8000_0010, 64'h0);
    chk("w3_rd_after_reset", rdata3, 64'hCAFE_F00D_1234_5678);
    rst_mid(8'hFF, 32'h8000_0018, 64'h5555_6666_7777_8888);
    idle(1, 3);
    issue(1, 8'h00, 32'h8000_0018, 64'h0);
    chk("w3_write_survives_reset", rdata3, 64'h5555_6666_7777_8888);
    random_phase(1, 40);

    idle(0, 10);
    chk("q0_drained", 64'(q0.size()), 64'h0);
    chk("q3_drained", 64'(q3.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
